// File: rtl/pcm_fifo.sv
// Sample FIFO for the PCM audio path: full-depth pointer FIFO with occupancy,
// almost-full/empty thresholds, sticky error flags, flush and optional FWFT read.
module pcm_fifo #(
  parameter int abits    = 10,
  parameter int dbits    = 16,
  parameter int af_level = 1020,
  parameter int ae_level = 4,
  parameter int fwft     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             wr,
  input  logic [dbits-1:0] din,
  input  logic             rd,
  output logic [dbits-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [abits:0]   count,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int             DEPTH  = 2**abits;
  localparam logic [abits:0] AF_LVL = (abits+1)'(af_level);
  localparam logic [abits:0] AE_LVL = (abits+1)'(ae_level);

  logic [abits:0]   wr_ptr_q, wr_ptr_d;
  logic [abits:0]   rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_acc, rd_acc;
  logic [dbits-1:0] mem_q [DEPTH];
  logic [dbits-1:0] rd_word;

  // Extra pointer MSB distinguishes full from empty so all entries are usable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[abits-1:0] == rd_ptr_q[abits-1:0]) &&
                 (wr_ptr_q[abits] != rd_ptr_q[abits]);
  assign count = wr_ptr_q - rd_ptr_q;

  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // A read frees a slot in the same cycle, so a full FIFO still accepts rd+wr.
  assign rd_acc = rd & ~clr & ~empty;
  assign wr_acc = wr & ~clr & (~full | rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr && !wr_acc) ovf_d = 1'b1;
      if (rd && !rd_acc) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is deliberately left out of reset and flush.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[abits-1:0]] <= din;
  end

  assign rd_word = mem_q[rd_ptr_q[abits-1:0]];

  generate
    if (fwft != 0) begin : g_fwft
      assign dout = empty ? '0 : rd_word;
    end else begin : g_reg
      logic [dbits-1:0] dout_q;

      // Nonblocking memory write means a same-address write is not seen here.
      always_ff @(posedge clk or posedge reset) begin
        if (reset)       dout_q <= '0;
        else if (clr)    dout_q <= '0;
        else if (rd_acc) dout_q <= rd_word;
      end

      assign dout = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_pcm_fifo.sv
// Directed bench for pcm_fifo: a registered-read and a FWFT instance share
// the same stimulus; status is checked on the registered instance.
module tb_pcm_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clr = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [15:0] din = '0;

  logic [15:0] dout_r, dout_f;
  logic        empty_r, full_r, af_r, ae_r, ovf_r, unf_r;
  logic        empty_f, full_f, af_f, ae_f, ovf_f, unf_f;
  logic [2:0]  count_r, count_f;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pcm_fifo #(.abits(2), .dbits(16), .af_level(3), .ae_level(1), .fwft(0)) u_reg (
    .clk(clk), .reset(reset), .clr(clr), .wr(wr), .din(din), .rd(rd),
    .dout(dout_r), .empty(empty_r), .full(full_r), .count(count_r),
    .almost_full(af_r), .almost_empty(ae_r), .overflow(ovf_r), .underflow(unf_r)
  );

  pcm_fifo #(.abits(2), .dbits(16), .af_level(3), .ae_level(1), .fwft(1)) u_fw (
    .clk(clk), .reset(reset), .clr(clr), .wr(wr), .din(din), .rd(rd),
    .dout(dout_f), .empty(empty_f), .full(full_f), .count(count_f),
    .almost_full(af_f), .almost_empty(ae_f), .overflow(ovf_f), .underflow(unf_f)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".dout_r"}, dout_r, 0);
    chk({tag, ".dout_f"}, dout_f, 0);
    chk({tag, ".empty"}, empty_r, 1);
    chk({tag, ".full"}, full_r, 0);
    chk({tag, ".count"}, count_r, 0);
    chk({tag, ".ae"}, ae_r, 1);
    chk({tag, ".af"}, af_r, 0);
    chk({tag, ".ovf"}, ovf_r, 0);
    chk({tag, ".unf"}, unf_r, 0);
  endtask

  logic [15:0] q[$];
  logic [15:0] exp_w;

  initial begin
    #1 reset = 1'b1;
    #3;
    chk_reset("rst");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Fill: thresholds af=3, ae=1, depth 4
    for (int i = 1; i <= 4; i++) begin
      wr = 1'b1; din = 16'(i);
      step();
      chk($sformatf("fill%0d.count", i), count_r, i);
      chk($sformatf("fill%0d.ae", i), ae_r, (i <= 1));
      chk($sformatf("fill%0d.af", i), af_r, (i >= 3));
      chk($sformatf("fill%0d.full", i), full_r, (i == 4));
      chk($sformatf("fill%0d.dout_f", i), dout_f, 16'h0001);
    end
    din = 16'h0005;
    step();
    wr = 1'b0;
    chk("ovf.flag", ovf_r, 1);
    chk("ovf.count", count_r, 4);
    chk("ovf.full", full_r, 1);

    // Drain; 0x0005 must not have landed anywhere
    for (int i = 1; i <= 4; i++) begin
      rd = 1'b1;
      step();
      chk($sformatf("drain%0d.dout_r", i), dout_r, i);
      chk($sformatf("drain%0d.dout_f", i), dout_f, (i < 4) ? i + 1 : 0);
      chk($sformatf("drain%0d.empty", i), empty_r, (i == 4));
    end
    step();
    rd = 1'b0;
    chk("unf.flag", unf_r, 1);
    chk("unf.dout_r", dout_r, 16'h0004);
    chk("unf.count", count_r, 0);

    // Flush clears flags and dout
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr1.ovf", ovf_r, 0);
    chk("clr1.unf", unf_r, 0);
    chk("clr1.dout_r", dout_r, 0);

    // Fill, then simultaneous rd+wr while full across pointer wrap
    q.delete();
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; din = 16'h0010 + 16'(i);
      q.push_back(din);
      step();
    end
    chk("sim.full0", full_r, 1);
    for (int k = 0; k < 6; k++) begin
      wr = 1'b1; rd = 1'b1; din = 16'h00A0 + 16'(k);
      exp_w = q.pop_front();
      q.push_back(din);
      step();
      chk($sformatf("sim%0d.dout_r", k), dout_r, exp_w);
      chk($sformatf("sim%0d.dout_f", k), dout_f, q[0]);
      chk($sformatf("sim%0d.full", k), full_r, 1);
      chk($sformatf("sim%0d.count", k), count_r, 4);
      chk($sformatf("sim%0d.ovf", k), ovf_r, 0);
    end
    wr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rd = 1'b1;
      exp_w = q.pop_front();
      step();
      chk($sformatf("wrap%0d.dout_r", k), dout_r, exp_w);
    end
    rd = 1'b0;
    chk("wrap.empty", empty_r, 1);
    chk("wrap.unf", unf_r, 0);

    // Empty with simultaneous rd+wr: write wins, read rejected
    wr = 1'b1; rd = 1'b1; din = 16'h0055;
    step();
    wr = 1'b0; rd = 1'b0;
    chk("erw.count", count_r, 1);
    chk("erw.unf", unf_r, 1);
    chk("erw.dout_r", dout_r, 16'h00A5);
    chk("erw.dout_f", dout_f, 16'h0055);
    rd = 1'b1;
    step();
    rd = 1'b0;
    chk("erw.rd.dout_r", dout_r, 16'h0055);
    chk("erw.rd.empty", empty_r, 1);

    // FWFT: word visible without rd, cleared to zero once drained
    wr = 1'b1; din = 16'h1234;
    step();
    wr = 1'b0;
    chk("fw.dout_f", dout_f, 16'h1234);
    chk("fw.empty", empty_f, 0);
    chk("fw.dout_r_hold", dout_r, 16'h0055);
    rd = 1'b1;
    step();
    rd = 1'b0;
    chk("fw.rd.dout_f", dout_f, 0);
    chk("fw.rd.empty", empty_f, 1);
    chk("fw.rd.dout_r", dout_r, 16'h1234);

    // count=3 with overflow set, then clr together with wr
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; din = 16'h0021 + 16'(i);
      step();
    end
    wr = 1'b0; rd = 1'b1;
    step();
    rd = 1'b0;
    chk("pre.count", count_r, 3);
    chk("pre.ovf", ovf_r, 1);
    chk("pre.dout_r", dout_r, 16'h0021);
    clr = 1'b1; wr = 1'b1; din = 16'h0099;
    step();
    clr = 1'b0; wr = 1'b0;
    chk("clr2.count", count_r, 0);
    chk("clr2.empty", empty_r, 1);
    chk("clr2.ovf", ovf_r, 0);
    chk("clr2.dout_r", dout_r, 0);
    chk("clr2.dout_f", dout_f, 0);

    // Reset mid-burst must take effect before the next edge
    wr = 1'b1; din = 16'h0031;
    step();
    din = 16'h0032;
    step();
    rd = 1'b1;
    step();
    chk("burst.count", count_r, 2);
    #2 reset = 1'b1;
    #1;
    chk_reset("arst");
    wr = 1'b0; rd = 1'b0;
    step();
    chk_reset("arst_hold");
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
